// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and dispatch: a circular FIFO of fetch packets
// that accepts up to `N packets and releases up to `N of the oldest packets each cycle.

`ifndef N
`define N 3
`endif
`ifndef NUM_SCALAR_BITS
`define NUM_SCALAR_BITS 2
`endif

package sys_defs_pkg;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } FETCH_PACKET;
endpackage

module inst_buffer
  import sys_defs_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  FETCH_PACKET [`N-1:0]            inst_buffer_inputs,
  input  logic [`NUM_SCALAR_BITS-1:0]     instructions_valid,
  output logic [`NUM_SCALAR_BITS-1:0]     inst_buffer_spots,
  input  logic                            restore_valid,
  output FETCH_PACKET [`N-1:0]            dispatch_packets,
  output logic [`NUM_SCALAR_BITS-1:0]     dispatch_available,
  input  logic [`NUM_SCALAR_BITS-1:0]     num_dispatched
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = `NUM_SCALAR_BITS;

  FETCH_PACKET     entries [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;

  logic [CW-1:0]   free_slots;
  logic [SW-1:0]   n_enq;
  logic [SW-1:0]   n_deq;
  logic [CW-1:0]   count_next;

  // Both advertised quantities come from registered state only, so fetch and
  // dispatch see stable values for the whole cycle.
  always_comb begin
    free_slots = CW'(DEPTH) - count;
    if (free_slots < CW'(`N)) inst_buffer_spots = SW'(free_slots);
    else                      inst_buffer_spots = SW'(`N);
    if (count < CW'(`N)) dispatch_available = SW'(count);
    else                 dispatch_available = SW'(`N);
  end

  // Requests beyond what was advertised are clamped so count never exceeds DEPTH.
  always_comb begin
    n_enq = (instructions_valid > inst_buffer_spots) ? inst_buffer_spots : instructions_valid;
    n_deq = (num_dispatched > dispatch_available) ? dispatch_available : num_dispatched;
    count_next = count + CW'(n_enq) - CW'(n_deq);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (restore_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(n_deq);
      tail  <= tail + PW'(n_enq);
      count <= count_next;
    end
  end

  // Storage is not reset; validity is tracked entirely by head/count.
  always_ff @(posedge clock) begin
    if (!reset && !restore_valid) begin
      for (int i = 0; i < `N; i++) begin
        if (i < int'(n_enq)) entries[tail + PW'(i)] <= inst_buffer_inputs[i];
      end
    end
  end

  always_comb begin
    dispatch_packets = '0;
    for (int i = 0; i < `N; i++) begin
      if (i < int'(dispatch_available)) dispatch_packets[i] = entries[head + PW'(i)];
    end
  end

  // Handshake: fetch may send at most inst_buffer_spots packets and dispatch may
  // take at most dispatch_available packets; a flush or reset cycle voids both.
  a_enq_within_spots: assert property (@(posedge clock) disable iff (reset || restore_valid)
    instructions_valid <= inst_buffer_spots);
  a_deq_within_available: assert property (@(posedge clock) disable iff (reset || restore_valid)
    num_dispatched <= dispatch_available);

endmodule

// File: doc/inst_buffer.md
INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the number of FETCH_PACKET entries; it SHALL be a power of two and at least `N.
REQ-002 SHALL use `N from sys_defs.svh as the superscalar width; counts SHALL be `NUM_SCALAR_BITS wide (holding 0..`N).
REQ-003 SHALL have port clock, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-005 SHALL have port inst_buffer_inputs, input, FETCH_PACKET [`N-1:0], the packets from fetch; index 0 is the oldest.
REQ-006 SHALL have port instructions_valid, input, `NUM_SCALAR_BITS, the number of valid packets in inst_buffer_inputs, always in the low indices.
REQ-007 SHALL have port inst_buffer_spots, output, `NUM_SCALAR_BITS, the number of packets fetch may send this cycle.
REQ-008 SHALL have port restore_valid, input, 1 bit, a branch mispredict flush.
REQ-009 SHALL have port dispatch_packets, output, FETCH_PACKET [`N-1:0], the oldest buffered packets; index 0 is the oldest.
REQ-010 SHALL have port dispatch_available, output, `NUM_SCALAR_BITS, the number of valid entries in dispatch_packets, equal to min(count, `N).
REQ-011 SHALL have port num_dispatched, input, `NUM_SCALAR_BITS, the number of packets dispatch consumes this cycle, always <= dispatch_available.

Function
REQ-012 SHALL be a circular FIFO with a head pointer, a tail pointer and a count register (width clog2(DEPTH+1)); the pointers SHALL wrap modulo DEPTH.
REQ-013 SHALL drive inst_buffer_spots combinationally from registered state only, as min(DEPTH - count, `N); it SHALL NOT depend on same-cycle num_dispatched or restore_valid.
REQ-014 SHALL, when restore_valid=0, write inst_buffer_inputs[0..instructions_valid-1] at tail, tail+1, ... (mod DEPTH) and advance tail by instructions_valid.
REQ-015 SHALL ignore packets at indices >= instructions_valid.
REQ-016 SHALL treat instructions_valid > inst_buffer_spots as a protocol violation; an assertion SHALL fire and the excess packets SHALL be dropped, with count never exceeding DEPTH.
REQ-017 SHALL drive dispatch_packets[i] = entry[(head+i) mod DEPTH] for i < dispatch_available, and drive '0 for all other indices.
REQ-018 SHALL, when restore_valid=0, advance head by num_dispatched.
REQ-019 SHALL update count as count + instructions_valid - num_dispatched when enqueue and dequeue occur in the same cycle.
REQ-020 SHALL make newly written packets visible to dispatch no earlier than the cycle after they are written (latency 1); there SHALL be no bypass from input to output.
REQ-021 SHALL, when restore_valid=1, set head, tail and count to 0 on the next edge, discarding that cycle's enqueue and dequeue; the priority order SHALL be reset > restore_valid > normal operation.
REQ-022 SHALL, when full (count=DEPTH), drive inst_buffer_spots=0; a same-cycle dequeue SHALL free space only from the following cycle.
REQ-023 SHALL, when empty, drive dispatch_available=0 and dispatch_packets='0.

Reset
REQ-024 SHALL, on reset=1 at a rising edge, set head=0, tail=0 and count=0; after reset, dispatch_available=0, dispatch_packets='0 and inst_buffer_spots=min(DEPTH,`N).
REQ-025 SHALL, when reset is asserted mid-operation, discard all contents and that cycle's enqueue, dequeue and restore; entry storage need not be cleared.

Verification
REQ-026 SHALL include this directed test (`N=3, DEPTH=8): reset -> spots=3, available=0; enqueue 3 packets with PCs 0,4,8 -> next cycle available=3, dispatch_packets PCs 0,4,8 in order.
REQ-027 SHALL include this directed test: fill to 8 with no dispatch -> spots=0; then dispatch 3 with enqueue 0 -> next cycle count=5, spots=3.
REQ-028 SHALL include this wrap-around test: drive tail to 7, enqueue 3 (PCs 0x40,0x44,0x48) -> they occupy entries 7,0,1 and are dispatched in PC order across the wrap.
REQ-029 SHALL include this simultaneous-event test: count=4, enqueue 2 and dispatch 3 in the same cycle -> next count=3, and the head packet is the 4th-oldest original.
REQ-030 SHALL include this flush test: count=6, restore_valid=1 with enqueue 3 and dispatch 2 -> next cycle count=0, available=0, spots=3.
REQ-031 SHALL include this test: assert reset while the buffer is full -> next cycle equals the post-reset state of REQ-024.
